// File: rtl/cpu_clk_pkg.sv
// rtl/cpu_clk_pkg.sv - shared constants for the CPU clock-enable controller
package cpu_clk_pkg;

    localparam int SPEED_W = 2;
    localparam int STATE_W = 2;

    localparam logic [STATE_W-1:0] ST_PAUSE = 2'd0;
    localparam logic [STATE_W-1:0] ST_RUN   = 2'd1;
    localparam logic [STATE_W-1:0] ST_HALT  = 2'd2;

endpackage

// File: rtl/cpu_clk_ctrl_tick_gen.sv
// rtl/cpu_clk_ctrl_tick_gen.sv - programmable divider producing one tick every div enabled cycles
module tick_gen #(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic             clr,
    input  logic [CNT_W-1:0] div,
    output logic             tick
);

    logic [CNT_W-1:0] div_cnt_q;
    logic [CNT_W-1:0] div_cnt_d;
    logic             at_end;

    // >= rather than == so a counter left above a shrunken divisor still wraps
    always_comb begin
        at_end    = (div_cnt_q >= (div - CNT_W'(1)));
        tick      = en & ~clr & at_end;
        div_cnt_d = div_cnt_q + CNT_W'(1);
        if (clr || !en || at_end) begin
            div_cnt_d = '0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            div_cnt_q <= '0;
        end else begin
            div_cnt_q <= div_cnt_d;
        end
    end

endmodule

// File: rtl/cpu_clk_ctrl.sv
// rtl/cpu_clk_ctrl.sv - run/pause/single-step/halt sequencer producing the CPU clock enable
module cpu_clk_ctrl
    import cpu_clk_pkg::*;
#(
    parameter int DIV_0 = 100000000,
    parameter int DIV_1 = 10000000,
    parameter int DIV_2 = 1000000,
    parameter int DIV_3 = 1,
    parameter int CNT_W = 32
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               go,
    input  logic               step,
    input  logic [SPEED_W-1:0] speed_sel,
    input  logic               halt,
    output logic               cpu_en,
    output logic               running,
    output logic               halted,
    output logic [CNT_W-1:0]   cycle_cnt
);

    logic [STATE_W-1:0] state_q, state_d;
    logic               cpu_en_q, cpu_en_d;
    logic [CNT_W-1:0]   cycle_cnt_q, cycle_cnt_d;
    logic               go_q, step_q;
    logic [SPEED_W-1:0] speed_q;

    logic               go_p, step_p, speed_chg;
    logic [CNT_W-1:0]   div_sel;
    logic               tick_en, tick_clr, tick;

    always_comb begin
        go_p      = go & ~go_q;
        step_p    = step & ~step_q;
        speed_chg = (speed_sel != speed_q);
        tick_en   = (state_q == ST_RUN);
        tick_clr  = go_p | halt | speed_chg;
        case (speed_q)
            2'd0:    div_sel = CNT_W'(DIV_0);
            2'd1:    div_sel = CNT_W'(DIV_1);
            2'd2:    div_sel = CNT_W'(DIV_2);
            default: div_sel = CNT_W'(DIV_3);
        endcase
    end

    tick_gen #(
        .CNT_W (CNT_W)
    ) u_tick_gen (
        .clk   (clk),
        .rst_n (rst_n),
        .en    (tick_en),
        .clr   (tick_clr),
        .div   (div_sel),
        .tick  (tick)
    );

    // Priority: halt > go_p > step_p > tick
    always_comb begin
        state_d  = state_q;
        cpu_en_d = 1'b0;
        case (state_q)
            ST_PAUSE: begin
                if (halt) begin
                    state_d = ST_HALT;
                end else if (go_p) begin
                    state_d = ST_RUN;
                end else if (step_p) begin
                    cpu_en_d = 1'b1;
                end
            end
            ST_RUN: begin
                if (halt) begin
                    state_d = ST_HALT;
                end else if (go_p) begin
                    state_d = ST_PAUSE;
                end else if (tick) begin
                    cpu_en_d = 1'b1;
                end
            end
            ST_HALT: begin
                if (go_p && !halt) begin
                    state_d = ST_PAUSE;
                end
            end
            default: begin
                state_d = ST_PAUSE;
            end
        endcase
    end

    always_comb begin
        cycle_cnt_d = cycle_cnt_q;
        if (cpu_en_q) begin
            cycle_cnt_d = cycle_cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_PAUSE;
            cpu_en_q    <= 1'b0;
            cycle_cnt_q <= '0;
            go_q        <= 1'b0;
            step_q      <= 1'b0;
            speed_q     <= '0;
        end else begin
            state_q     <= state_d;
            cpu_en_q    <= cpu_en_d;
            cycle_cnt_q <= cycle_cnt_d;
            go_q        <= go;
            step_q      <= step;
            speed_q     <= speed_sel;
        end
    end

    assign cpu_en    = cpu_en_q;
    assign running   = (state_q == ST_RUN);
    assign halted    = (state_q == ST_HALT);
    assign cycle_cnt = cycle_cnt_q;

endmodule
